shift_exec_stage: RTL and testbench

//  EX-stage wrapper around the combinational shifter. Accepts decoded SLL/SRL/SRA(I) ops from decode via valid/ready.

---
 rtl/shift_exec_stage.sv | 184 ++++++++++++++++++
 tb/tb_shift_exec_stage.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_stage.sv
// rtl/shift_exec_stage.sv - two-stage EX wrapper around an external combinational shifter
//
// Accepts decoded SLL/SRL/SRA(I) ops over a valid/ready handshake, registers
// the operands in S1, drives the external shifter from S1, and captures the
// shifter result in S2 for writeback. Latency 2, throughput 1 op/cycle, with
// backpressure and flush.
//
// Optional feature: define SHIFT_FWD_EN to forward this unit's own results
// into the rs1 operand at S1 load.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   flush                kill all in-flight ops; blocks acceptance this cycle
//   in_valid/in_ready    decode handshake
//   in_funct3            001=SLL, 101=SRL/SRA
//   in_funct7b5          instr[30]; selects SRA when funct3=101
//   in_is_imm            shamt from in_imm_shamt (1) or in_rs2_data[4:0] (0)
//   in_imm_shamt         instr[24:20]
//   in_rs1_addr          rs1 index (forwarding match only)
//   in_rs1_data          rs1 value from regfile
//   in_rs2_data          rs2 value from regfile
//   in_rd                destination register
//   sh_in/sh_shamt/sh_alu  to shifter (alu: 00=SLL, 01=SRA, 10=SRL)
//   sh_out               shifter result, combinational from sh_*
//   out_valid/out_ready  writeback handshake
//   out_result           shifted value (0 for illegal ops)
//   out_rd               destination register
//   out_illegal          op had an unsupported funct3/funct7 encoding

module shift_exec_stage #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic            in_is_imm,
    input  logic [4:0]      in_imm_shamt,
    input  logic [RAW-1:0]  in_rs1_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [RAW-1:0]  in_rd,
    output logic [XLEN-1:0] sh_in,
    output logic [4:0]      sh_shamt,
    output logic [1:0]      sh_alu,
    input  logic [XLEN-1:0] sh_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RAW-1:0]  out_rd,
    output logic            out_illegal
);

    localparam logic [1:0] SEL_SLL = 2'b00;
    localparam logic [1:0] SEL_SRA = 2'b01;
    localparam logic [1:0] SEL_SRL = 2'b10;

    // S1 registers
    logic            r_s1_valid;
    logic [XLEN-1:0] r_s1_rs1;
    logic [4:0]      r_s1_shamt;
    logic [1:0]      r_s1_sel;
    logic            r_s1_illegal;
    logic [RAW-1:0]  r_s1_rd;

    // S2 registers
    logic            r_s2_valid;
    logic [XLEN-1:0] r_out_result;
    logic [RAW-1:0]  r_out_rd;
    logic            r_out_illegal;

    logic            w_s2_adv;
    logic            w_s1_adv;
    logic            w_in_fire;
    logic            w_s2_load;
    logic [1:0]      w_sel;
    logic [4:0]      w_shamt;
    logic            w_illegal;
    logic [XLEN-1:0] w_rs1_op;
    logic            w_unused;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv && !flush;
    assign w_in_fire = in_valid && in_ready;
    assign w_s2_load = r_s1_valid && w_s2_adv && !flush;

    // Only the low 5 bits of rs2 form a shift amount; the address is only
    // consumed when forwarding is built in.
    assign w_unused = ^{in_rs2_data[XLEN-1:5], in_rs1_addr};

    // Decode: illegal encodings are carried through as a zero-shift SLL so
    // the shifter sees a benign operation; the result is zeroed at S2 load.
    always_comb begin
        w_sel     = SEL_SLL;
        w_shamt   = in_is_imm ? in_imm_shamt : in_rs2_data[4:0];
        w_illegal = 1'b0;
        if (in_funct3 == 3'b001 && !in_funct7b5) begin
            w_sel = SEL_SLL;
        end else if (in_funct3 == 3'b101 && !in_funct7b5) begin
            w_sel = SEL_SRL;
        end else if (in_funct3 == 3'b101 && in_funct7b5) begin
            w_sel = SEL_SRA;
        end else begin
            w_sel     = SEL_SLL;
            w_shamt   = 5'd0;
            w_illegal = 1'b1;
        end
    end

`ifdef SHIFT_FWD_EN
    // The S1 op is younger than the S2 op, so its live shifter output wins.
    // x0 is never forwarded.
    always_comb begin
        w_rs1_op = in_rs1_data;
        if (in_rs1_addr != '0) begin
            if (r_s1_valid && r_s1_rd == in_rs1_addr && !r_s1_illegal) begin
                w_rs1_op = sh_out;
            end else if (r_s2_valid && r_out_rd == in_rs1_addr && !r_out_illegal) begin
                w_rs1_op = r_out_result;
            end
        end
    end
`else
    assign w_rs1_op = in_rs1_data;
`endif

    // S1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_rs1     <= '0;
            r_s1_shamt   <= '0;
            r_s1_sel     <= SEL_SLL;
            r_s1_illegal <= 1'b0;
            r_s1_rd      <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid   <= 1'b1;
            r_s1_rs1     <= w_rs1_op;
            r_s1_shamt   <= w_shamt;
            r_s1_sel     <= w_sel;
            r_s1_illegal <= w_illegal;
            r_s1_rd      <= in_rd;
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_valid    <= 1'b0;
            r_out_result  <= '0;
            r_out_rd      <= '0;
            r_out_illegal <= 1'b0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid    <= 1'b1;
            r_out_result  <= r_s1_illegal ? '0 : sh_out;
            r_out_rd      <= r_s1_rd;
            r_out_illegal <= r_s1_illegal;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    // Shifter drive is forced to zero whenever S1 holds no op.
    assign sh_in    = r_s1_valid ? r_s1_rs1   : '0;
    assign sh_shamt = r_s1_valid ? r_s1_shamt : '0;
    assign sh_alu   = r_s1_valid ? r_s1_sel   : SEL_SLL;

    assign out_valid   = r_s2_valid;
    assign out_result  = r_out_result;
    assign out_rd      = r_out_rd;
    assign out_illegal = r_out_illegal;

endmodule

// File: tb/tb_shift_exec_stage.sv
// tb/tb_shift_exec_stage.sv - directed and randomized bench for shift_exec_stage

module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = 3'd0;
    logic        in_funct7b5 = 1'b0;
    logic        in_is_imm = 1'b0;
    logic [4:0]  in_imm_shamt = 5'd0;
    logic [4:0]  in_rs1_addr = 5'd0;
    logic [31:0] in_rs1_data = 32'd0;
    logic [31:0] in_rs2_data = 32'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [31:0] sh_in;
    logic [4:0]  sh_shamt;
    logic [1:0]  sh_alu;
    logic [31:0] sh_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    always #5 clk = ~clk;

    shift_exec_stage #(.XLEN(32), .RAW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_is_imm(in_is_imm), .in_imm_shamt(in_imm_shamt),
        .in_rs1_addr(in_rs1_addr), .in_rs1_data(in_rs1_data),
        .in_rs2_data(in_rs2_data), .in_rd(in_rd),
        .sh_in(sh_in), .sh_shamt(sh_shamt), .sh_alu(sh_alu), .sh_out(sh_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal)
    );

    // External combinational shifter the stage drives.
    always_comb begin
        case (sh_alu)
            2'b00:   sh_out = sh_in << sh_shamt;
            2'b01:   sh_out = $unsigned($signed(sh_in) >>> sh_shamt);
            2'b10:   sh_out = sh_in >> sh_shamt;
            default: sh_out = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        illegal;
    } op_t;

    op_t inflight[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  n_out = 0;
    bit  last_acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected writeback for the op currently on the input, from the ISA rules.
    function automatic op_t model();
        logic [31:0] x;
        logic [4:0]  s;
        op_t         e;
        bit          found;
        x = in_rs1_data;
        found = 0;
`ifdef SHIFT_FWD_EN
        if (in_rs1_addr != 5'd0) begin
            for (int i = inflight.size() - 1; i >= 0; i--) begin
                if (!found && inflight[i].rd == in_rs1_addr && !inflight[i].illegal) begin
                    x = inflight[i].result;
                    found = 1;
                end
            end
        end
`endif
        s = in_is_imm ? in_imm_shamt : in_rs2_data[4:0];
        e.rd = in_rd;
        e.illegal = 1'b0;
        if (in_funct3 == 3'b001 && !in_funct7b5)
            e.result = x << s;
        else if (in_funct3 == 3'b101 && !in_funct7b5)
            e.result = x >> s;
        else if (in_funct3 == 3'b101)
            e.result = (x >> s) | (x[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
        else begin
            e.result  = 32'h0;
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    // Pre-edge check of the handshake and scoreboard, then advance one cycle.
    task automatic tick();
        int  n;
        bit  acc;
        bit  outh;
        op_t e;
        #1;
        n = inflight.size();
        chk("in_ready", {31'b0, in_ready}, {31'b0, !flush && (n < 2 || out_ready)});
        if (n == 0) chk("out_valid_idle", {31'b0, out_valid}, 32'd0);
        acc  = in_valid && in_ready;
        outh = out_valid && out_ready;
        if (acc) e = model();
        if (outh && n > 0) begin
            chk("sb_result",  out_result, inflight[0].result);
            chk("sb_rd",      {27'b0, out_rd}, {27'b0, inflight[0].rd});
            chk("sb_illegal", {31'b0, out_illegal}, {31'b0, inflight[0].illegal});
            void'(inflight.pop_front());
            n_out++;
        end
        if (flush) inflight.delete();
        if (acc) inflight.push_back(e);
        last_acc = acc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_op(input logic [2:0] f3, input logic b5, input logic imm,
                          input logic [4:0] sh, input logic [4:0] a, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [4:0] rd);
        in_valid     = 1'b1;
        in_funct3    = f3;
        in_funct7b5  = b5;
        in_is_imm    = imm;
        in_imm_shamt = sh;
        in_rs1_addr  = a;
        in_rs1_data  = d1;
        in_rs2_data  = d2;
        in_rd        = rd;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && inflight.size() > 0; i++) tick();
        chk("drain", inflight.size(), 32'd0);
    endtask

    int  acc_cnt;
    int  out_start;
    bit  pend;

    initial begin
        // reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",   {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid",  {31'b0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_sh_in",      sh_in, 32'd0);
        chk("rst_sh_alu",     {30'b0, sh_alu}, 32'd0);
        rst = 1'b1;
        tick();

        // T1: SLL register form
        out_ready = 1'b1;
        set_op(3'b001, 1'b0, 1'b0, 5'd0, 5'd1, 32'h0000_0001, 32'd31, 5'd3);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t1_sh_alu",    {30'b0, sh_alu}, 32'd0);
        chk("t1_sh_shamt",  {27'b0, sh_shamt}, 32'd31);
        chk("t1_sh_in",     sh_in, 32'd1);
        chk("t1_out_valid_early", {31'b0, out_valid}, 32'd0);
        tick();
        #1;
        chk("t1_out_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_result",    out_result, 32'h8000_0000);
        chk("t1_rd",        {27'b0, out_rd}, 32'd3);
        tick();

        // T2: SRA then SRL, immediate shamt 4, back to back
        set_op(3'b101, 1'b1, 1'b1, 5'd4, 5'd2, 32'h8000_0000, 32'h0, 5'd4);
        tick();
        set_op(3'b101, 1'b0, 1'b1, 5'd4, 5'd2, 32'h8000_0000, 32'h0, 5'd5);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t2_sra", out_result, 32'hF800_0000);
        tick();
        #1;
        chk("t2_srl", out_result, 32'h0800_0000);
        tick();

        // T4: illegal encoding
        set_op(3'b001, 1'b1, 1'b1, 5'd7, 5'd1, 32'h1234_5678, 32'h0, 5'd9);
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        chk("t4_illegal", {31'b0, out_illegal}, 32'd1);
        chk("t4_result",  out_result, 32'd0);
        tick();

        // T3: backpressure with four queued ops
        out_ready = 1'b0;
        acc_cnt = 0;
        out_start = n_out;
        for (int c = 0; c < 40 && (acc_cnt < 4 || inflight.size() > 0); c++) begin
            out_ready = (c >= 3);
            if (acc_cnt < 4)
                set_op(3'b001, 1'b0, 1'b1, 5'(acc_cnt + 1), 5'd0, 32'h0000_0011, 32'h0, 5'(10 + acc_cnt));
            else
                in_valid = 1'b0;
            if (c == 2) begin
                #1;
                chk("t3_in_ready_low", {31'b0, in_ready}, 32'd0);
            end
            tick();
            if (last_acc) acc_cnt++;
        end
        chk("t3_accepted", acc_cnt, 32'd4);
        chk("t3_emerged",  n_out - out_start, 32'd4);

        // T6: dependent shift pair
        out_ready = 1'b1;
        set_op(3'b001, 1'b0, 1'b1, 5'd1, 5'd1, 32'd3, 32'h0, 5'd5);
        tick();
        set_op(3'b101, 1'b0, 1'b1, 5'd1, 5'd5, 32'h0000_0100, 32'h0, 5'd6);
        tick();
        in_valid = 1'b0;
        tick();
        #1;
`ifdef SHIFT_FWD_EN
        chk("t6_fwd", out_result, 32'd3);
`else
        chk("t6_nofwd", out_result, 32'h0000_0080);
`endif
        tick();

        // T5: flush with both stages full and an op offered
        out_ready = 1'b0;
        set_op(3'b001, 1'b0, 1'b1, 5'd1, 5'd0, 32'h1, 32'h0, 5'd1);
        tick();
        set_op(3'b001, 1'b0, 1'b1, 5'd2, 5'd0, 32'h1, 32'h0, 5'd2);
        tick();
        set_op(3'b001, 1'b0, 1'b1, 5'd3, 5'd0, 32'h1, 32'h0, 5'd3);
        flush = 1'b1;
        #1;
        chk("t5_in_ready_flush", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t5_out_valid", {31'b0, out_valid}, 32'd0);
        chk("t5_in_ready",  {31'b0, in_ready}, 32'd1);
        chk("t5_sh_alu",    {30'b0, sh_alu}, 32'd0);
        tick();

        // reset mid-operation
        out_ready = 1'b0;
        set_op(3'b101, 1'b1, 1'b1, 5'd3, 5'd0, 32'hF000_0000, 32'h0, 5'd7);
        tick();
        set_op(3'b101, 1'b0, 1'b1, 5'd3, 5'd0, 32'hF000_0000, 32'h0, 5'd8);
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mrst_out_valid",  {31'b0, out_valid}, 32'd0);
        chk("mrst_in_ready",   {31'b0, in_ready}, 32'd1);
        chk("mrst_out_result", out_result, 32'd0);
        chk("mrst_sh_in",      sh_in, 32'd0);
        inflight.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();

        // randomized traffic
        pend = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend) begin
                in_valid     = ($urandom_range(0, 9) < 7);
                case ($urandom_range(0, 3))
                    0:       in_funct3 = 3'b001;
                    1, 2:    in_funct3 = 3'b101;
                    default: in_funct3 = 3'($urandom);
                endcase
                in_funct7b5  = ($urandom_range(0, 3) == 0);
                in_is_imm    = 1'($urandom);
                in_imm_shamt = 5'($urandom);
                in_rs1_addr  = 5'($urandom_range(0, 7));
                in_rs1_data  = $urandom;
                in_rs2_data  = $urandom;
                in_rd        = 5'($urandom_range(0, 7));
                pend         = in_valid;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 39) == 0);
            tick();
            if (last_acc || flush) pend = 0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
